mem_system: RTL and testbench

// - Parametrised successor of the single-cycle data/stack/MMIO memory wrapper.
// - Decodes word addresses into DATA, STACK and MMIO banks with a registered, region-selected

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_bank.sv | 26 ++
 rtl/mem_im.sv | 22 ++
 rtl/mem_system.sv | 177 +++++++++++++++++
 tb/tb_mem_system.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the data/stack/MMIO memory system.
// Also holds the constant functions used to reject bad region maps at elaboration.
package mem_pkg;

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_STACK = 2'd1,
    REG_MMIO  = 2'd2,
    REG_FAULT = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DW          = 32;
  localparam int DEF_AW          = 16;
  localparam int DEF_DATA_BASE   = 'h0000;
  localparam int DEF_DATA_DEPTH  = 4096;
  localparam int DEF_STACK_BASE  = 'hE000;
  localparam int DEF_STACK_DEPTH = 1024;
  localparam int DEF_MMIO_BASE   = 'hFF00;
  localparam int DEF_MMIO_DEPTH  = 64;
  localparam int DEF_MMIO_WAIT   = 2;

  // A region must be a power-of-two size starting on a multiple of that size.
  function automatic bit region_ok(input int base, input int depth);
    return (depth > 1) && ((depth & (depth - 1)) == 0) && ((base & (depth - 1)) == 0);
  endfunction

  // Two aligned power-of-two regions overlap iff they agree above the larger one's span.
  function automatic bit regions_overlap(input int base_a, input int depth_a,
                                         input int base_b, input int depth_b);
    int span;
    span = (depth_a > depth_b) ? depth_a : depth_b;
    return (base_a & ~(span - 1)) == (base_b & ~(span - 1));
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port RAM bank: synchronous write, registered read, read-before-write.
// Contents are deliberately not reset.
module mem_bank #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_im.sv
// Instruction memory: small fixed boot program, every other address reads as NOP.
// Purely combinational so fetch never contends with data accesses.
module mem_im #(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr
);

  always_comb begin
    instr = DW'(32'h0000_0013);
    case (pc)
      AW'(0):  instr = DW'(32'h0010_0093);
      AW'(1):  instr = DW'(32'h0020_0113);
      AW'(2):  instr = DW'(32'h0020_81b3);
      AW'(3):  instr = DW'(32'h0000_006f);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_system.sv
// Memory system between core and banks: address decode into DATA/STACK/MMIO,
// one-in-flight request/response protocol with MMIO wait states, unmapped-access faults.
module mem_system
  import mem_pkg::*;
#(
  parameter int            DW          = DEF_DW,
  parameter int            AW          = DEF_AW,
  parameter logic [AW-1:0] DATA_BASE   = 16'h0000,
  parameter int            DATA_DEPTH  = DEF_DATA_DEPTH,
  parameter logic [AW-1:0] STACK_BASE  = 16'hE000,
  parameter int            STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [AW-1:0] MMIO_BASE   = 16'hFF00,
  parameter int            MMIO_DEPTH  = DEF_MMIO_DEPTH,
  parameter int            MMIO_WAIT   = DEF_MMIO_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_fault
);

  localparam int DA_W = $clog2(DATA_DEPTH);
  localparam int SA_W = $clog2(STACK_DEPTH);
  localparam int MA_W = $clog2(MMIO_DEPTH);
  localparam logic [3:0] WAIT_INIT = (MMIO_WAIT > 0) ? 4'(MMIO_WAIT - 1) : 4'd0;

  if (!region_ok(32'(DATA_BASE), DATA_DEPTH) || !region_ok(32'(STACK_BASE), STACK_DEPTH) ||
      !region_ok(32'(MMIO_BASE), MMIO_DEPTH)) begin : g_bad_region
    $error("mem_system: region base/depth not aligned power of two");
  end
  if (regions_overlap(32'(DATA_BASE), DATA_DEPTH, 32'(STACK_BASE), STACK_DEPTH) ||
      regions_overlap(32'(DATA_BASE), DATA_DEPTH, 32'(MMIO_BASE), MMIO_DEPTH) ||
      regions_overlap(32'(STACK_BASE), STACK_DEPTH, 32'(MMIO_BASE), MMIO_DEPTH)) begin : g_overlap
    $error("mem_system: overlapping regions");
  end
  if (MMIO_WAIT < 0 || MMIO_WAIT > 15) begin : g_bad_wait
    $error("mem_system: MMIO_WAIT out of range 0..15");
  end

  state_t          state, state_next;
  region_t         hit_region, lat_region;
  logic            lat_we;
  logic [MA_W-1:0] lat_mmio_addr;
  logic [DW-1:0]   lat_wdata;
  logic [3:0]      wait_cnt;
  logic            accept;

  logic [DA_W-1:0] data_paddr;
  logic [SA_W-1:0] stack_paddr;
  logic [MA_W-1:0] mmio_paddr;

  logic            data_en, data_we, stack_en, stack_we, mmio_en, mmio_we;
  logic [MA_W-1:0] mmio_addr;
  logic [DW-1:0]   mmio_wdata;
  logic [DW-1:0]   data_rd, stack_rd, mmio_rd;

  assign data_paddr  = DA_W'(req_addr - DATA_BASE);
  assign stack_paddr = SA_W'(req_addr - STACK_BASE);
  assign mmio_paddr  = MA_W'(req_addr - MMIO_BASE);

  always_comb begin
    hit_region = REG_FAULT;
    if ((req_addr & ~AW'(DATA_DEPTH - 1)) == DATA_BASE) begin
      hit_region = REG_DATA;
    end else if ((req_addr & ~AW'(STACK_DEPTH - 1)) == STACK_BASE) begin
      hit_region = REG_STACK;
    end else if ((req_addr & ~AW'(MMIO_DEPTH - 1)) == MMIO_BASE) begin
      hit_region = REG_MMIO;
    end
  end

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_* are valid only in the single rsp_valid cycle.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    data_en    = accept && (hit_region == REG_DATA);
    data_we    = data_en && req_we;
    stack_en   = accept && (hit_region == REG_STACK);
    stack_we   = stack_en && req_we;
    mmio_en    = 1'b0;
    mmio_we    = 1'b0;
    mmio_addr  = lat_mmio_addr;
    mmio_wdata = lat_wdata;
    if (MMIO_WAIT == 0) begin
      mmio_en    = accept && (hit_region == REG_MMIO);
      mmio_we    = mmio_en && req_we;
      mmio_addr  = mmio_paddr;
      mmio_wdata = req_wdata;
    end else begin
      // MMIO side effects happen only on the WAIT->RESP edge, so a reset in WAIT drops them.
      mmio_en = (state == WAIT) && (wait_cnt == 4'd0) && (lat_region == REG_MMIO);
      mmio_we = mmio_en && lat_we;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ((hit_region == REG_MMIO) && (MMIO_WAIT > 0)) ? WAIT : RESP;
        end
      end
      WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_region    <= REG_FAULT;
      lat_we        <= 1'b0;
      lat_mmio_addr <= '0;
      lat_wdata     <= '0;
      wait_cnt      <= 4'd0;
    end else if (accept) begin
      lat_region    <= hit_region;
      lat_we        <= req_we;
      lat_mmio_addr <= mmio_paddr;
      lat_wdata     <= req_wdata;
      wait_cnt      <= WAIT_INIT;
    end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_fault = rsp_valid && (lat_region == REG_FAULT);

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !lat_we) begin
      case (lat_region)
        REG_DATA:  rsp_rdata = data_rd;
        REG_STACK: rsp_rdata = stack_rd;
        REG_MMIO:  rsp_rdata = mmio_rd;
        default:   rsp_rdata = '0;
      endcase
    end
  end

  mem_bank #(.DW(DW), .DEPTH(DATA_DEPTH)) u_data (
    .clk(clk), .en(data_en), .we(data_we), .addr(data_paddr), .wdata(req_wdata), .rdata(data_rd)
  );

  mem_bank #(.DW(DW), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .en(stack_en), .we(stack_we), .addr(stack_paddr), .wdata(req_wdata), .rdata(stack_rd)
  );

  mem_bank #(.DW(DW), .DEPTH(MMIO_DEPTH)) u_mmio (
    .clk(clk), .en(mmio_en), .we(mmio_we), .addr(mmio_addr), .wdata(mmio_wdata), .rdata(mmio_rd)
  );

  mem_im #(.DW(DW), .AW(AW)) u_im (
    .pc(pc), .instr(instr)
  );

endmodule

// File: tb/tb_mem_system.sv
// Bench for mem_system: two instances (MMIO_WAIT=2 and MMIO_WAIT=0) checked against
// an address-map / associative-memory reference model with directed and random requests.
module tb_mem_system;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc        [2];
  logic [DW-1:0] instr     [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          rsp_fault [2];

  int            n_vec = 0;
  int            n_err = 0;
  int            wait_of [2];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_system #(.MMIO_WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .pc(pc[0]), .instr(instr[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
  );

  mem_system #(.MMIO_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .pc(pc[1]), .instr(instr[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Address map from the region table: 0=DATA 1=STACK 2=MMIO 3=unmapped.
  function automatic int region_of(input logic [AW-1:0] a);
    if (a < 16'h1000) return 0;
    if (a >= 16'hE000 && a < 16'hE400) return 1;
    if (a >= 16'hFF00 && a < 16'hFF40) return 2;
    return 3;
  endfunction

  // Caller is at a negedge; returns at the negedge after the response pulse.
  task automatic do_req(input int idx, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input string tag);
    int            reg_i;
    int            key;
    int            lat;
    int            low;
    int            guard;
    int            exp_lat;
    logic [DW-1:0] exp_rd;
    reg_i   = region_of(addr);
    key     = idx * 65536 + int'(addr);
    exp_lat = (reg_i == 2) ? 1 + wait_of[idx] : 1;
    exp_rd  = '0;
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    guard = 0;
    while (!req_ready[idx] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accept"}, DW'(req_ready[idx]), 32'd1);
    if (reg_i != 3) begin
      if (we) ref_mem[key] = wdata;
      else if (ref_mem.exists(key)) exp_rd = ref_mem[key];
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    lat = 1;
    low = 0;
    while (!rsp_valid[idx] && lat < 40) begin
      if (!req_ready[idx]) low++;
      @(negedge clk);
      lat++;
    end
    if (!req_ready[idx]) low++;
    check({tag, " latency"}, DW'(lat), DW'(exp_lat));
    check({tag, " ready_low"}, DW'(low), DW'(exp_lat));
    check({tag, " rdata"}, rsp_rdata[idx], exp_rd);
    check({tag, " fault"}, DW'(rsp_fault[idx]), DW'(reg_i == 3));
    @(negedge clk);
    check({tag, " pulse"}, DW'(rsp_valid[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] b2b_addr [4];
    int            acc_cyc[$];
    int            issued;
    int            n_rsp;
    logic          acc;
    logic          seen;
    wait_of[0] = 2;
    wait_of[1] = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pc[i] = '0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset ready", DW'(req_ready[0]), 32'd1);
    check("reset rsp_valid", DW'(rsp_valid[0]), 32'd0);
    check("reset rdata", rsp_rdata[0], 32'd0);
    check("reset fault", DW'(rsp_fault[0]), 32'd0);
    reset = 1'b0;
    pc[0] = 16'h0000;
    pc[1] = 16'h0100;
    #1;
    check("instr pc0", instr[0], 32'h0010_0093);
    check("instr nop", instr[1], 32'h0000_0013);
    @(negedge clk);

    do_req(0, 1'b1, 16'h0010, 32'hDEADBEEF, "data_wr");
    do_req(0, 1'b0, 16'h0010, 32'h0, "data_rd");
    do_req(0, 1'b1, 16'hE005, 32'h11111111, "stack_wr");
    do_req(0, 1'b1, 16'h0005, 32'h22222222, "data5_wr");
    do_req(0, 1'b0, 16'hE005, 32'h0, "stack_rd");
    do_req(0, 1'b0, 16'h0005, 32'h0, "data5_rd");
    do_req(0, 1'b1, 16'hFF03, 32'h0000_0033, "mmio_wr_w2");
    do_req(0, 1'b0, 16'hFF03, 32'h0, "mmio_rd_w2");
    do_req(1, 1'b1, 16'hFF03, 32'h0000_0044, "mmio_wr_w0");
    do_req(1, 1'b0, 16'hFF03, 32'h0, "mmio_rd_w0");
    do_req(0, 1'b1, 16'h0000, 32'hCAFE0000, "data0_wr");
    do_req(0, 1'b1, 16'h8000, 32'h12345678, "fault_wr");
    do_req(0, 1'b0, 16'h0000, 32'h0, "data0_rd");
    do_req(0, 1'b1, 16'h0FFF, 32'h0BAD0FFF, "data_top_wr");
    do_req(0, 1'b0, 16'h0FFF, 32'h0, "data_top_rd");
    do_req(0, 1'b0, 16'h1000, 32'h0, "above_data");
    do_req(0, 1'b1, 16'hE3FF, 32'h5A5A5A5A, "stack_top_wr");
    do_req(0, 1'b0, 16'hE3FF, 32'h0, "stack_top_rd");
    do_req(0, 1'b0, 16'hDFFF, 32'h0, "below_stack");
    do_req(0, 1'b0, 16'hFF40, 32'h0, "above_mmio");
    do_req(0, 1'b0, 16'hFFFF, 32'h0, "wrap_top");

    // Reset while an MMIO write sits in WAIT.
    do_req(0, 1'b1, 16'hFF00, 32'h0000_00A5, "mmio_a5_wr");
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'hFF00; req_wdata[0] = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("midwait ready", DW'(req_ready[0]), 32'd0);
    reset = 1'b1;
    #1;
    check("midwait rst ready", DW'(req_ready[0]), 32'd1);
    check("midwait rst rsp_valid", DW'(rsp_valid[0]), 32'd0);
    check("midwait rst rdata", rsp_rdata[0], 32'd0);
    check("midwait rst fault", DW'(rsp_fault[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    check("midwait no rsp", DW'(seen), 32'd0);
    do_req(0, 1'b0, 16'hFF00, 32'h0, "mmio_a5_rd");

    // Reset in the response cycle of a DATA write: the write already landed.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0020; req_wdata[0] = 32'h0000_0077;
    ref_mem[16'h0020] = 32'h0000_0077;
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(0, 1'b0, 16'h0020, 32'h0, "data_commit_rd");

    // Back-to-back reads with req_valid held high.
    b2b_addr[0] = 16'h0010; b2b_addr[1] = 16'h0005; b2b_addr[2] = 16'h0000; b2b_addr[3] = 16'h0020;
    issued = 0;
    n_rsp  = 0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = b2b_addr[0];
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid[0]) begin
        n_rsp++;
        check("b2b overlap", DW'(req_ready[0]), 32'd0);
        if (exp_q.size() > 0) check("b2b rdata", rsp_rdata[0], exp_q.pop_front());
        else check("b2b extra rsp", DW'(rsp_valid[0]), 32'd0);
      end
      acc = req_valid[0] && req_ready[0];
      if (acc) begin
        exp_q.push_back(ref_mem[int'(b2b_addr[issued])]);
        acc_cyc.push_back(c);
      end
      @(negedge clk);
      if (acc) begin
        issued++;
        if (issued < 4) req_addr[0] = b2b_addr[issued];
        else req_valid[0] = 1'b0;
      end
    end
    check("b2b accepts", DW'(issued), 32'd4);
    check("b2b responses", DW'(n_rsp), 32'd4);
    check("b2b queue empty", DW'(exp_q.size()), 32'd0);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("b2b spacing", DW'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end

    // Random traffic on both instances.
    for (int idx = 0; idx < 2; idx++) begin
      for (int n = 0; n < 30; n++) begin
        int            r;
        int            depth;
        int            base;
        int            off;
        logic          we;
        logic [AW-1:0] a;
        r  = $urandom_range(0, 3);
        we = 1'($urandom_range(0, 1));
        case (r)
          0:       begin base = 'h0000; depth = 4096; end
          1:       begin base = 'hE000; depth = 1024; end
          default: begin base = 'hFF00; depth = 64;   end
        endcase
        off = ($urandom_range(0, 3) == 0) ? depth - 1 : $urandom_range(0, 7);
        a   = AW'(base + off);
        if (r == 3) begin
          a = AW'($urandom_range(0, 65535));
          while (region_of(a) != 3) a = AW'($urandom_range(0, 65535));
        end else if (!we && !ref_mem.exists(idx * 65536 + int'(a))) begin
          we = 1'b1;
        end
        do_req(idx, we, a, $urandom, $sformatf("rand%0d_%0d", idx, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
